uart_cfg_ctrl: RTL and testbench

//  Command controller sequencing the UART receiver and configuring its trigger path.

---
 rtl/uart_cfg_ctrl.sv | 120 ++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_cfg_ctrl.sv
// uart_cfg_ctrl: drains UART receiver bytes into 3-byte {op,hi,lo} commands and
// drives the receiver's baud/match/mask configuration plus the gated trigger output.
module uart_cfg_ctrl #(
  parameter logic [15:0] BAUD_DFLT   = 16'd2604,
  parameter logic [15:0] BAUD_MIN    = 16'd16,
  parameter logic [19:0] TIMEOUT_CYC = 20'd65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  rx_data,
  input  logic        uart_trig,
  output logic        clr_rdy,
  output logic [15:0] baud_cnt,
  output logic [7:0]  match,
  output logic [7:0]  mask,
  output logic        trig_en,
  output logic        trig_out,
  output logic        cmd_done,
  output logic        cmd_err
);
  typedef enum logic [1:0] {IDLE, GOT_OP, GOT_HI, EXEC} state_t;
  localparam logic [19:0] TO_LAST = TIMEOUT_CYC - 20'd1;
  state_t      r_state;
  logic [7:0]  r_op, r_hi, r_lo;
  logic [19:0] r_cnt;
  logic        r_clr_rdy, r_trig_en, r_trig_out, r_done, r_err;
  logic [15:0] r_baud;
  logic [7:0]  r_match, r_mask;
  logic        w_accept, w_wait, w_timeout;
  logic [15:0] w_val;
  // No accept in EXEC or while acknowledging, so a held rdy is never double-counted.
  assign w_accept  = rdy & ~r_clr_rdy & (r_state != EXEC);
  assign w_wait    = (r_state == GOT_OP) | (r_state == GOT_HI);
  assign w_timeout = w_wait & ~w_accept & (r_cnt == TO_LAST);
  assign w_val     = {r_hi, r_lo};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= 8'h00;
      r_hi       <= 8'h00;
      r_lo       <= 8'h00;
      r_cnt      <= 20'd0;
      r_clr_rdy  <= 1'b0;
      r_baud     <= BAUD_DFLT;
      r_match    <= 8'h00;
      r_mask     <= 8'hFF;
      r_trig_en  <= 1'b0;
      r_trig_out <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_clr_rdy  <= w_accept;
      r_trig_out <= uart_trig & r_trig_en;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= (w_accept | ~w_wait | w_timeout) ? 20'd0 : r_cnt + 20'd1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_op    <= rx_data;
          r_state <= GOT_OP;
        end
        GOT_OP: if (w_accept) begin
          r_hi    <= rx_data;
          r_state <= GOT_HI;
        end else if (w_timeout) begin
          r_state <= IDLE;
          r_err   <= 1'b1;
        end
        GOT_HI: if (w_accept) begin
          r_lo    <= rx_data;
          r_state <= EXEC;
        end else if (w_timeout) begin
          r_state <= IDLE;
          r_err   <= 1'b1;
        end
        EXEC: begin
          r_state <= IDLE;
          case (r_op)
            8'h00: r_done <= 1'b1;
            8'h01: if (w_val < BAUD_MIN) r_err <= 1'b1;
                   else begin
                     r_baud <= w_val;
                     r_done <= 1'b1;
                   end
            8'h02: begin
              r_match <= r_lo;
              r_done  <= 1'b1;
            end
            8'h03: begin
              r_mask <= r_lo;
              r_done <= 1'b1;
            end
            8'h04: begin
              r_trig_en <= r_lo[0];
              r_done    <= 1'b1;
            end
            8'h05: begin
              r_baud    <= BAUD_DFLT;
              r_match   <= 8'h00;
              r_mask    <= 8'hFF;
              r_trig_en <= 1'b0;
              r_done    <= 1'b1;
            end
            default: r_err <= 1'b1;
          endcase
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign clr_rdy  = r_clr_rdy;
  assign baud_cnt = r_baud;
  assign match    = r_match;
  assign mask     = r_mask;
  assign trig_en  = r_trig_en;
  assign trig_out = r_trig_out;
  assign cmd_done = r_done;
  assign cmd_err  = r_err;
endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// tb_uart_cfg_ctrl: queue-based command model checked every cycle, plus directed
// literal expectations for reset, each opcode, rejects, timeout and handshake corners.
module tb_uart_cfg_ctrl;
  logic clk = 0, rst_n, rdy, uart_trig;
  logic [7:0] rx_data;
  logic clr_rdy, trig_en, trig_out, cmd_done, cmd_err;
  logic [15:0] baud_cnt;
  logic [7:0] match, mask;
  int tests = 0, errors = 0, clr_cnt = 0, err_cnt = 0;
  uart_cfg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rx_data(rx_data), .uart_trig(uart_trig),
    .clr_rdy(clr_rdy), .baud_cnt(baud_cnt), .match(match), .mask(mask),
    .trig_en(trig_en), .trig_out(trig_out), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  // Model: bytes collected so far, idle-cycle count, expected outputs.
  logic [7:0] q[$];
  bit m_exec, acc;
  int idle;
  logic [15:0] v, e_baud;
  logic [7:0] e_match, e_mask;
  logic e_clr, e_ten, e_tout, e_done, e_err;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_exec = 0; idle = 0; e_clr = 0; e_baud = 16'd2604; e_match = 0;
      e_mask = 8'hFF; e_ten = 0; e_tout = 0; e_done = 0; e_err = 0;
    end else begin
      acc = rdy && !e_clr && !m_exec;
      e_tout = uart_trig && e_ten;
      e_clr = acc; e_done = 0; e_err = 0;
      if (m_exec) begin
        v = {q[1], q[2]};
        if (q[0] == 8'h00) e_done = 1;
        else if (q[0] == 8'h01) begin
          if (v < 16) e_err = 1; else begin e_baud = v; e_done = 1; end
        end
        else if (q[0] == 8'h02) begin e_match = q[2]; e_done = 1; end
        else if (q[0] == 8'h03) begin e_mask = q[2]; e_done = 1; end
        else if (q[0] == 8'h04) begin e_ten = q[2][0]; e_done = 1; end
        else if (q[0] == 8'h05) begin
          e_baud = 16'd2604; e_match = 0; e_mask = 8'hFF; e_ten = 0; e_done = 1;
        end
        else e_err = 1;
        q.delete(); m_exec = 0;
      end else if (acc) begin
        q.push_back(rx_data); idle = 0; m_exec = (q.size() == 3);
      end else if (q.size() > 0) begin
        idle++;
        if (idle == 65536) begin q.delete(); idle = 0; e_err = 1; end
      end
    end
  end
  always @(negedge clk) if (rst_n === 1'b1) begin
    if (clr_rdy) clr_cnt++;
    if (cmd_err) err_cnt++;
    chk("clr_rdy", clr_rdy, e_clr);
    chk("baud_cnt", baud_cnt, e_baud);
    chk("match", match, e_match);
    chk("mask", mask, e_mask);
    chk("trig_en", trig_en, e_ten);
    chk("trig_out", trig_out, e_tout);
    chk("cmd_done", cmd_done, e_done);
    chk("cmd_err", cmd_err, e_err);
  end
  task automatic send(input logic [7:0] b, input bit drop = 1);
    int n = 0;
    @(negedge clk); rdy = 1; rx_data = b;
    do begin @(negedge clk); n++; end while (!clr_rdy && n < 8);
    chk("send_ack", clr_rdy, 1);
    if (drop) rdy = 0;
  endtask
  task automatic cmd(input logic [7:0] op, hi, lo);
    send(op); send(hi); send(lo);
    @(negedge clk);
  endtask
  int c0, e0;
  initial begin
    rst_n = 0; rdy = 0; rx_data = 0; uart_trig = 0;
    repeat (3) @(negedge clk);
    chk("rst_baud", baud_cnt, 16'd2604);
    chk("rst_match", match, 8'h00);
    chk("rst_mask", mask, 8'hFF);
    chk("rst_pulses", {trig_en, trig_out, clr_rdy, cmd_done, cmd_err}, 5'b0);
    rst_n = 1;
    cmd(8'h01, 8'h00, 8'h05);
    chk("lowbaud_err", cmd_err, 1);
    chk("lowbaud_keep", baud_cnt, 16'd2604);
    c0 = clr_cnt;
    cmd(8'h01, 8'h01, 8'h45);
    chk("baud_val", baud_cnt, 16'h0145);
    chk("baud_done", cmd_done, 1);
    chk("baud_clrs", clr_cnt - c0, 3);
    cmd(8'h02, 8'h11, 8'hA5);
    chk("match_val", match, 8'hA5);
    cmd(8'h03, 8'h22, 8'h0F);
    chk("mask_val", mask, 8'h0F);
    uart_trig = 1; @(negedge clk);
    chk("trig_gated", trig_out, 0);
    uart_trig = 0;
    cmd(8'h04, 8'h00, 8'h01);
    chk("trig_en_on", trig_en, 1);
    uart_trig = 1; @(negedge clk);
    chk("trig_out_hi", trig_out, 1);
    uart_trig = 0; @(negedge clk);
    chk("trig_out_lo", trig_out, 0);
    cmd(8'h7E, 8'h00, 8'h00);
    chk("badop_err", cmd_err, 1);
    chk("badop_nodone", cmd_done, 0);
    cmd(8'h05, 8'h00, 8'h00);
    chk("soft_rst", {baud_cnt, match, mask, 7'b0, trig_en}, {16'd2604, 8'h00, 8'hFF, 8'h00});
    e0 = err_cnt;
    send(8'h02);
    repeat (65540) @(negedge clk);
    chk("timeout_err", err_cnt - e0, 1);
    cmd(8'h03, 8'h00, 8'hF0);
    chk("after_to_mask", mask, 8'hF0);
    chk("after_to_match", match, 8'h00);
    // Byte offered during EXEC and held: waits, then exactly one accept.
    c0 = clr_cnt;
    send(8'h02); send(8'h00); send(8'h3C, 0);
    rx_data = 8'h04;
    @(negedge clk);
    chk("exec_match", match, 8'h3C);
    repeat (2) @(negedge clk);
    rdy = 0;
    @(negedge clk);
    chk("held_accepts", clr_cnt - c0, 4);
    send(8'h00); send(8'h00);
    @(negedge clk);
    chk("held_cmd_done", cmd_done, 1);
    chk("held_trig_en", trig_en, 0);
    send(8'h01); send(8'h00);
    @(negedge clk); rst_n = 0;
    @(negedge clk);
    chk("midrst", {baud_cnt, match, mask, 7'b0, trig_en}, {16'd2604, 8'h00, 8'hFF, 8'h00});
    rst_n = 1;
    cmd(8'h03, 8'h00, 8'h33);
    chk("midrst_mask", mask, 8'h33);
    chk("midrst_match", match, 8'h00);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
